// File: rtl/arith_arbiter.sv
// Arbitrates N_REQ requesters onto one 2-bit arithmetic unit and returns the result over valid/ready.
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module arith_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [3*N_REQ-1:0]   req_op,
    input  logic [2*N_REQ-1:0]   req_a,
    input  logic [2*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_data,
    output logic [2:0]           rsp_id,
    input  logic                 rsp_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_id_q, rsp_id_d;
    logic [2:0]       op_q, op_d;
    logic [1:0]       a_q, a_d;
    logic [1:0]       b_q, b_d;
    logic [2:0]       id_q, id_d;
`ifdef ARB_RR_EN
    logic [2:0]       ptr_q, ptr_d;
`endif

    logic             win_found_s;
    logic [2:0]       win_idx_s;
    logic [N_REQ-1:0] win_oh_s;
    logic [2:0]       win_op_s;
    logic [1:0]       win_a_s;
    logic [1:0]       win_b_s;
    logic             rsp_fire_s;

    // Results wrap modulo 8; operands are unsigned 0..3.
    function automatic logic [2:0] alu_calc(input logic [2:0] op, input logic [1:0] a,
                                            input logic [1:0] b);
        logic [2:0] ax;
        logic [2:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        case (op)
            3'b000:  alu_calc = ax;
            3'b001:  alu_calc = ax + bx;
            3'b010:  alu_calc = bx - 3'd1;
            3'b011:  alu_calc = (ax >= bx) ? (ax - bx) : (bx - ax);
            3'b100:  alu_calc = {b, 1'b0};
            3'b101:  alu_calc = {2'b00, a[1]};
            3'b110:  alu_calc = ax + 3'd1;
            3'b111:  alu_calc = bx;
            default: alu_calc = 3'd0;
        endcase
    endfunction

    assign rsp_fire_s = rsp_valid_q && rsp_ready;

    // Winner search: slot k is the k-th candidate in priority order; first requesting slot wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        win_oh_s    = '0;
        win_op_s    = 3'd0;
        win_a_s     = 2'd0;
        win_b_s     = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!win_found_s && req[i] &&
`ifdef ARB_RR_EN
                    (ptr_q == 3'((i - k + N_REQ) % N_REQ))
`else
                    (i == k)
`endif
                   ) begin
                    win_found_s = 1'b1;
                    win_idx_s   = 3'(i);
                    win_oh_s[i] = 1'b1;
                    win_op_s    = req_op[3*i +: 3];
                    win_a_s     = req_a[2*i +: 2];
                    win_b_s     = req_b[2*i +: 2];
                end else begin
                    win_found_s = win_found_s;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (rsp_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; inputs are only looked at in IDLE.
    always_comb begin
        gnt_d       = '0;
        busy_d      = (state_d != ST_IDLE);
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
`ifdef ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    gnt_d = win_oh_s;
                    op_d  = win_op_s;
                    a_d   = win_a_s;
                    b_d   = win_b_s;
                    id_d  = win_idx_s;
`ifdef ARB_RR_EN
                    ptr_d = ({1'b0, win_idx_s} + 4'd1 >= 4'(N_REQ)) ? 3'd0 : (win_idx_s + 3'd1);
`endif
                end else begin
                    gnt_d = '0;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_calc(op_q, a_q, b_q);
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
            end
            ST_RESP: begin
                if (rsp_fire_s) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = rsp_valid_q;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Output and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 3'd0;
            rsp_id_q    <= 3'd0;
            op_q        <= 3'd0;
            a_q         <= 2'd0;
            b_q         <= 2'd0;
            id_q        <= 3'd0;
`ifdef ARB_RR_EN
            ptr_q       <= 3'd0;
`endif
        end else begin
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
`ifdef ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_arith_arbiter.sv
// Self-checking bench for arith_arbiter: directed and random transactions against an arithmetic model.
module tb_arith_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [3*N-1:0] req_op;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [N-1:0]  gnt;
    logic          busy;
    logic          rsp_valid;
    logic [2:0]    rsp_data;
    logic [2:0]    rsp_id;
    logic          rsp_ready;

    int vectors     = 0;
    int miscompares = 0;
    int ptr         = 0;
    int sweep_exp [8] = '{2, 2, 7, 2, 0, 1, 3, 0};

    always #5 clk = ~clk;

    arith_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_res(input int op, input int a, input int b);
        case (op)
            0:       return a;
            1:       return a + b;
            2:       return (b + 7) % 8;
            3:       return (a > b) ? a - b : b - a;
            4:       return 2 * b;
            5:       return a / 2;
            6:       return a + 1;
            default: return b;
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] rv);
        int i;
        for (int k = 0; k < N; k++) begin
`ifdef ARB_RR_EN
            i = (ptr + k) % N;
`else
            i = k;
`endif
            if (rv[i]) return i;
        end
        return 0;
    endfunction

    task automatic txn(input logic [N-1:0] rv, input logic [3*N-1:0] ops, input logic [2*N-1:0] as,
                       input logic [2*N-1:0] bs, input int stall, input bit scramble, input int exp_ovr);
        int w;
        int exp_res;
        w = pick(rv);
        exp_res = (exp_ovr >= 0) ? exp_ovr :
                  ref_res(int'(ops[3*w +: 3]), int'(as[2*w +: 2]), int'(bs[2*w +: 2]));
        req = rv; req_op = ops; req_a = as; req_b = bs;
        rsp_ready = (stall == 0);
        step();
        chk("gnt", 8'(gnt), 8'(1 << w));
        chk("busy_at_grant", 8'(busy), 8'd1);
        ptr = (w + 1) % N;
        req[w] = 1'b0;
        if (scramble) begin
            req_op = 12'($urandom);
            req_a  = 8'($urandom);
            req_b  = 8'($urandom);
        end
        step();
        chk("gnt_pulse_end", 8'(gnt), 8'd0);
        chk("rsp_valid", 8'(rsp_valid), 8'd1);
        chk("rsp_data", 8'(rsp_data), 8'(exp_res));
        chk("rsp_id", 8'(rsp_id), 8'(w));
        for (int c = 0; c < stall; c++) begin
            step();
            chk("stall_valid", 8'(rsp_valid), 8'd1);
            chk("stall_data", 8'(rsp_data), 8'(exp_res));
            chk("stall_id", 8'(rsp_id), 8'(w));
            chk("stall_gnt", 8'(gnt), 8'd0);
            chk("stall_busy", 8'(busy), 8'd1);
        end
        rsp_ready = 1'b1;
        step();
        chk("valid_drop", 8'(rsp_valid), 8'd0);
        chk("busy_drop", 8'(busy), 8'd0);
    endtask

    initial begin
        logic [3*N-1:0] ops;
        logic [2*N-1:0] as;
        logic [2*N-1:0] bs;
        int w;

        rst_n = 1'b0; req = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        step();
        step();
        chk("rst_gnt", 8'(gnt), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_valid", 8'(rsp_valid), 8'd0);
        chk("rst_data", 8'(rsp_data), 8'd0);
        chk("rst_id", 8'(rsp_id), 8'd0);
        rst_n = 1'b1;

        // Contention with all requesters re-asserting.
        for (int t = 0; t < 5; t++) begin
            txn(4'b1111, 12'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, -1);
        end

        // Single op on requester 2.
        ops = 12'($urandom); as = 8'($urandom); bs = 8'($urandom);
        ops[8:6] = 3'b001; as[5:4] = 2'd3; bs[5:4] = 2'd3;
        txn(4'b0100, ops, as, bs, 0, 1'b0, 6);

        // Opcode sweep with a=2, b=0.
        for (int k = 0; k < 8; k++) begin
            ops = 12'($urandom); as = 8'($urandom); bs = 8'($urandom);
            ops[2:0] = 3'(k); as[1:0] = 2'd2; bs[1:0] = 2'd0;
            txn(4'b0001, ops, as, bs, 0, 1'b0, sweep_exp[k]);
        end

        // Back-pressure with other requests pending.
        txn(4'b1011, 12'($urandom), 8'($urandom), 8'($urandom), 5, 1'b0, -1);

        // Operands change after grant.
        txn(4'b0010, 12'($urandom), 8'($urandom), 8'($urandom), 1, 1'b1, -1);

        // Reset during RESP.
        req = 4'b1111; req_op = 12'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
        rsp_ready = 1'b0;
        w = pick(req);
        step();
        chk("mid_gnt", 8'(gnt), 8'(1 << w));
        req[w] = 1'b0;
        step();
        chk("mid_valid", 8'(rsp_valid), 8'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 8'(rsp_valid), 8'd0);
        chk("mid_rst_busy", 8'(busy), 8'd0);
        chk("mid_rst_gnt", 8'(gnt), 8'd0);
        chk("mid_rst_data", 8'(rsp_data), 8'd0);
        ptr = 0;
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        txn(4'b1111, 12'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, -1);

        // Random traffic.
        for (int t = 0; t < 24; t++) begin
            txn(4'($urandom_range(1, 15)), 12'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 2)), 1'($urandom), -1);
        end

        req = '0;
        step();
        chk("idle_gnt", 8'(gnt), 8'd0);
        chk("idle_busy", 8'(busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arith_arbiter.md
# arith_arbiter

Shares one 2-bit arithmetic unit between `N_REQ` requesters. Each requester presents an opcode and two 2-bit operands. A one-hot grant accepts one request. The block computes the 3-bit result on the latched operands and returns it with the requester ID over a valid/ready response channel. It sits between client FSMs and the shared arithmetic datapath, and implements the arithmetic function internally.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset. One clock domain; reset is asynchronous and active-low.
- `req`  in  N_REQ: request per requester; held until that requester's `gnt`.
- `req_op`  in  3*N_REQ: opcode of requester i in bits [3i+2:3i].
- `req_a`  in  2*N_REQ: operand a of requester i in bits [2i+1:2i].
- `req_b`  in  2*N_REQ: operand b of requester i, packed the same way.
- `gnt`  out  N_REQ: one-hot, one-cycle pulse; that requester's op/a/b have been captured.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `rsp_valid`  out  1: result available.
- `rsp_data`  out  3: result, two's-complement wrap.
- `rsp_id`  out  3: index of the granted requester; unused upper bits are 0.
- `rsp_ready`  in  1: consumer accepts the response.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE, no `req`:** stay in IDLE.
- **IDLE, any `req` bit set:**
  - Arbitrate and latch the winner's op/a/b/index.
  - Pulse `gnt[winner]` for the next cycle.
  - Go to EXEC.
- **EXEC:**
  - Compute on the latched operands and register into `rsp_data`/`rsp_id`.
  - Set `rsp_valid`.
  - Go to RESP.
- **RESP:**
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` stable.
  - When `rsp_valid && rsp_ready`, clear `rsp_valid` and go to IDLE.
- **Input changes outside IDLE:** `req`/op/operand changes during EXEC/RESP are ignored.
- **Requester handshake:** a requester deasserts `req` in its `gnt` cycle. If `req` is still high when IDLE is next sampled, that is a new request.
- **Opcode results** (3-bit, a and b unsigned 0..3):
  - 000: a
  - 001: a+b (max 6)
  - 010: b-1 (b=0 gives 3'b111)
  - 011: |a-b|
  - 100: b<<1
  - 101: a>>1
  - 110: a+1
  - 111: b
- **Arbitration:** set by `ARB_RR_EN` (see Configuration).
- **Reset:** asynchronous.
  - State goes to IDLE and the RR pointer to 0.
  - `gnt`, `busy`, `rsp_valid`, `rsp_data` and `rsp_id` all go to 0.
  - An in-flight operation is dropped with no response.

## Timing
- Request sampled at edge E0 (state IDLE).
- `gnt` and `busy` are high in cycle E0..E1.
- `rsp_valid` rises after E1, a request-to-valid latency of 2 cycles.
- With `rsp_ready` held high, the handshake completes at E2 and IDLE resamples at E3. Peak throughput is one operation per 3 cycles.
- **Back-pressure:** `rsp_ready` low holds RESP indefinitely, with outputs stable.
- **`busy` window:** high from the cycle after E0 through the cycle of the response handshake.
- **`rsp_ready` outside RESP:** ignored.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- **`ARB_RR_EN` defined:** round-robin arbitration.
  - The search starts at pointer p, ascending with wrap.
  - After granting i, p becomes (i+1) mod N_REQ.
  - p resets to 0.
- **`ARB_RR_EN` undefined:** fixed priority, lowest index wins. No pointer register exists.

## Test plan
- **Single op:** reset, then `req[2]`=1 with op=001, a=3, b=3.
  - `gnt`=4'b0100 for one cycle.
  - 2 cycles later: `rsp_valid`=1, `rsp_data`=6, `rsp_id`=2.
- **Opcode sweep:** every opcode with a=2, b=0 → results 2, 2, 7 (3'b111), 2, 0, 1, 3, 0.
- **Contention:** `req`=4'b1111 held, with each requester re-asserting after its response.
  - With `ARB_RR_EN`: grants in order 0, 1, 2, 3, 0.
  - Without `ARB_RR_EN`: requester 0 is granted every time.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_valid`, `rsp_data` and `rsp_id` stay constant, and no `gnt` is issued.
  - `rsp_ready`=1 → `rsp_valid` drops after the next edge.
- **Operands changing after grant:** change op/a/b of the granted requester during EXEC → the result reflects the values captured at grant.
- **Reset mid-operation:** assert `rst_n`=0 during RESP.
  - `rsp_valid`, `busy` and `gnt` go to 0 immediately.
  - After release, with `req` held, the next grant goes to requester 0 (pointer reset).
